load_store_unit: RTL
====================

# load_store_unit

Multi-cycle load/store unit for the RISC-V core, directly downstream of the ALU. It takes the effective address the ALU produces for LW/LH/LB/LBU/LHU/SW/SH/SB (ADD op, `alu_out`), performs one word-wide memory transaction over a ready/valid-style bus with byte strobes, and returns sign- or zero-extended load data for writeback. Misaligned and unsupported accesses are trapped locally and never reach memory.

## Interface
- `TIMEOUT`, default 255: max cycles `mem_req` stays high without `mem_ready` before aborting with error; 0 disables the timeout.

- `clk` in 1: single clock; all state updates on rising edge.
- `reset` in 1: asynchronous, active-high; forces FSM to IDLE and all registered outputs to reset values.
- `start` in 1: request strobe; accepted only in IDLE.
- `is_store` in 1: 1 = store, 0 = load; sampled with `start`.
- `funct3` in 3: access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU (BU/HU loads only).
- `addr` in 32: effective byte address from ALU `alu_out`.
- `wdata` in 32: store data (rs2).
- `busy` out 1: high from accept until the cycle after `done`.
- `done` out 1: one-cycle completion pulse.
- `err` out 1: valid with `done`; 1 = misaligned, unsupported, or timed out.
- `rdata` out 32: extended load result; updated at `done` of a successful load, held otherwise.
- `mem_req` out 1: bus request; held until `mem_ready`.
- `mem_we` out 1: write enable.
- `mem_addr` out 32: word address, `{addr[31:2], 2'b00}`.
- `mem_wstrb` out 4: byte-lane enables (stores only; 0000 for loads).
- `mem_wdata` out 32: lane-replicated store data.
- `mem_rdata` in 32: read data, valid when `mem_req && mem_ready`.
- `mem_ready` in 1: transaction complete this cycle.

## Operation
- FSM states: IDLE, ACCESS, DONE.
- IDLE: when `start`=1, latch `is_store`, `funct3`, `addr[1:0]`, and all memory-side outputs.
  - Legal, aligned access: go to ACCESS.
  - Otherwise: go to DONE with `err`=1 and no memory access.
- Alignment rules:
  - H/HU/SH: `addr[0]` must be 0.
  - W/SW: `addr[1:0]` must be 00.
  - B/BU/SB: any address.
- Unsupported encodings:
  - Loads: funct3 011, 110, 111.
  - Stores: any funct3 with bit 2 set, or 011.
- ACCESS: `mem_req`=1, outputs stable. On `mem_ready`=1, capture `mem_rdata` (loads) and go to DONE.
  - Timeout counter counts cycles in ACCESS. When the count reaches `TIMEOUT` without `mem_ready`, go to DONE with `err`=1.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `start` outside IDLE is ignored: no queueing, no error.
- Store lanes, with `o = addr[1:0]`:
  - SB: `mem_wdata` = `{4{wdata[7:0]}}`, `mem_wstrb` = `0001 << o`.
  - SH: `mem_wdata` = `{2{wdata[15:0]}}`, `mem_wstrb` = 0011 (o=0) or 1100 (o=2).
  - SW: `mem_wdata` = `wdata`, `mem_wstrb` = 1111.
- Load extraction: byte `mem_rdata[8*o +: 8]`, half `mem_rdata[16*o[1] +: 16]`.
  - B/H sign-extend; BU/HU zero-extend; W passes through unchanged.
- `rdata` is left unchanged on stores and on any `err` completion.

## Timing
- Reset values: `busy`=0, `done`=0, `err`=0, `rdata`=0, `mem_req`=0, `mem_we`=0, `mem_addr`=0, `mem_wstrb`=0, `mem_wdata`=0.
- `start` at edge N (legal access):
  - `mem_req`=1 from cycle N+1.
  - If `mem_ready`=1 in cycle N+1+k, `done` is high in cycle N+2+k.
  - Minimum latency is 2 cycles, start to done.
- Illegal access: `done`/`err` in cycle N+1, and `mem_req` never asserts.
- `busy` is high cycles N+1 through the `done` cycle inclusive. A new `start` is accepted in the cycle `busy` falls, giving back-to-back throughput of one access per 2+k+1 cycles.
- `mem_ready` is ignored when `mem_req`=0.
- `reset` asserted mid-ACCESS: `mem_req` drops asynchronously, no `done` pulse, and the transaction is abandoned.
- Timeout: with `TIMEOUT`=T, `done`/`err` occurs T+1 cycles after the first ACCESS cycle.

## Test plan
- LW `addr`=0x100, `mem_rdata`=0xDEADBEEF, `mem_ready` tied 1:
  - `mem_addr`=0x100, `mem_wstrb`=0000, `done` 2 cycles after `start`, `rdata`=0xDEADBEEF, `err`=0.
- LB/LBU `addr`=0x103, `mem_rdata`=0x80FF7F01:
  - LB gives `rdata`=0xFFFFFF80; LBU gives 0x00000080.
  - LH `addr`=0x102 gives 0xFFFF80FF.
- SB `addr`=0x201, `wdata`=0x123456AB:
  - `mem_wdata`=0xABABABAB, `mem_wstrb`=0010, `mem_we`=1.
  - SH `addr`=0x202 gives `mem_wstrb`=1100, `mem_wdata`=0x56AB56AB.
- LW `addr`=0x102, and SH `addr`=0x201:
  - `mem_req` stays 0; `done`=`err`=1 one cycle after `start`; `rdata` unchanged.
- `mem_ready` held 0 with `TIMEOUT`=4:
  - `done`/`err`=1 after 5 ACCESS cycles.
  - Repeat with `reset` pulsed in the 2nd ACCESS cycle: `mem_req` drops immediately, no `done`, `busy`=0.
- `start` re-asserted while `busy`: ignored; exactly one `done` per accepted request.

Source files
------------

// File: rtl/load_store_unit.sv
// Word-wide load/store unit: traps misaligned/unsupported accesses locally and
// runs one bus transaction otherwise, returning extended load data at done.
module load_store_unit #(
    parameter int TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic [31:0] rdata,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    input  logic        mem_ready
);

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_ACCESS = 2'd1;
    localparam logic [1:0] S_DONE   = 2'd2;

    localparam int            CW   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam logic [CW-1:0] TMAX = CW'(TIMEOUT);

    logic [1:0]    state_q, state_d;
    logic          is_store_q, is_store_d;
    logic [2:0]    funct3_q, funct3_d;
    logic [1:0]    off_q, off_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          done_q, done_d;
    logic          err_q, err_d;
    logic [31:0]   rdata_q, rdata_d;
    logic          mem_req_q, mem_req_d;
    logic          mem_we_q, mem_we_d;
    logic [31:0]   mem_addr_q, mem_addr_d;
    logic [3:0]    mem_wstrb_q, mem_wstrb_d;
    logic [31:0]   mem_wdata_q, mem_wdata_d;

    // Request decode: encodings that do not exist for the direction, and size/offset clashes
    logic unsupported;
    logic misaligned;
    logic legal;

    assign unsupported = is_store ? (funct3[2] || (funct3[1:0] == 2'b11))
                                  : ((funct3 == 3'b011) || (funct3[2:1] == 2'b11));
    assign misaligned  = ((funct3[1:0] == 2'b01) && addr[0]) ||
                         ((funct3[1:0] == 2'b10) && (addr[1:0] != 2'b00));
    assign legal       = !unsupported && !misaligned;

    // Store lane steering: data is replicated so every candidate lane carries it
    logic [3:0]  lane_strb;
    logic [31:0] lane_data;

    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
        localparam logic [1:0] LANE = 2'(gi);
        assign lane_strb[gi] = (funct3[1:0] == 2'b00) ? (addr[1:0] == LANE) :
                               (funct3[1:0] == 2'b01) ? (addr[1] == LANE[1]) : 1'b1;
        assign lane_data[8*gi +: 8] = (funct3[1:0] == 2'b00) ? wdata[7:0] :
                                      (funct3[1:0] == 2'b01) ? wdata[8*(gi%2) +: 8] :
                                                               wdata[8*gi +: 8];
    end

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_value;

    assign ld_byte = mem_rdata[{off_q, 3'b000} +: 8];
    assign ld_half = mem_rdata[{off_q[1], 4'b0000} +: 16];

    always_comb begin
        ld_value = mem_rdata;
        case (funct3_q)
            3'b000:  ld_value = {{24{ld_byte[7]}}, ld_byte};
            3'b100:  ld_value = {24'd0, ld_byte};
            3'b001:  ld_value = {{16{ld_half[15]}}, ld_half};
            3'b101:  ld_value = {16'd0, ld_half};
            default: ld_value = mem_rdata;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        is_store_d  = is_store_q;
        funct3_d    = funct3_q;
        off_d       = off_q;
        cnt_d       = cnt_q;
        done_d      = 1'b0;
        err_d       = err_q;
        rdata_d     = rdata_q;
        mem_req_d   = mem_req_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wstrb_d = mem_wstrb_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    is_store_d  = is_store;
                    funct3_d    = funct3;
                    off_d       = addr[1:0];
                    cnt_d       = '0;
                    mem_we_d    = is_store;
                    mem_addr_d  = {addr[31:2], 2'b00};
                    mem_wstrb_d = is_store ? lane_strb : 4'b0000;
                    mem_wdata_d = lane_data;
                    if (legal) begin
                        state_d   = S_ACCESS;
                        mem_req_d = 1'b1;
                        err_d     = 1'b0;
                    end else begin
                        state_d = S_DONE;
                        done_d  = 1'b1;
                        err_d   = 1'b1;
                    end
                end
            end
            S_ACCESS: begin
                if (mem_ready) begin
                    state_d   = S_DONE;
                    mem_req_d = 1'b0;
                    done_d    = 1'b1;
                    err_d     = 1'b0;
                    if (!is_store_q) begin
                        rdata_d = ld_value;
                    end
                end else if ((TIMEOUT != 0) && (cnt_q == TMAX)) begin
                    state_d   = S_DONE;
                    mem_req_d = 1'b0;
                    done_d    = 1'b1;
                    err_d     = 1'b1;
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                err_d   = 1'b0;
            end
            default: begin
                state_d   = S_IDLE;
                mem_req_d = 1'b0;
                err_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            is_store_q  <= 1'b0;
            funct3_q    <= 3'b000;
            off_q       <= 2'b00;
            cnt_q       <= '0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            rdata_q     <= 32'd0;
            mem_req_q   <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wstrb_q <= 4'b0000;
            mem_wdata_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            is_store_q  <= is_store_d;
            funct3_q    <= funct3_d;
            off_q       <= off_d;
            cnt_q       <= cnt_d;
            done_q      <= done_d;
            err_q       <= err_d;
            rdata_q     <= rdata_d;
            mem_req_q   <= mem_req_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wstrb_q <= mem_wstrb_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign busy      = (state_q != S_IDLE);
    assign done      = done_q;
    assign err       = err_q;
    assign rdata     = rdata_q;
    assign mem_req   = mem_req_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wstrb = mem_wstrb_q;
    assign mem_wdata = mem_wdata_q;

endmodule
